// File: rtl/dpd_pkg.sv
// dpd_pkg
//   Shared definitions for the DPD alignment delay line:
//   - state_t : fill/run state encoding (ST_FILL, ST_RUN)
//   - clamp_delay : maps a requested delay onto the legal range 1..dmax
package dpd_pkg;

  // FILL: line is refilling after reset or a delay load, outputs gated.
  // RUN : every accepted sample produces a delayed output.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A zero delay makes no sense for a read-before-write buffer, so it is
  // treated as one sample; anything beyond the buffer depth saturates.
  function automatic int clamp_delay(input int req, input int dmax);
    if (req <= 0) begin
      return 1;
    end else if (req > dmax) begin
      return dmax;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/delay_ram.sv
// delay_ram
//   Simple dual-port RAM: one write port, one registered read port.
//   On an address collision the read returns the old contents
//   (read-before-write). Small depths map to distributed RAM, larger ones
//   to block RAM; the read register's synchronous reset maps onto the
//   block RAM output-register reset.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset of the read register only
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   re    - read enable (read register loads only when high)
//   raddr - read address
//   rdata - registered read data, holds when re is low
module delay_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  // Contents are never reset; the surrounding logic never exposes
  // unwritten words.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of mem in the same edge as the write gives the old
  // word on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dpd_align_delay.sv
// dpd_align_delay
//   Programmable multi-channel sample delay used to line up the DPD
//   feedback path with the reference path. Delay is counted in accepted
//   samples (in_valid), not clock cycles, and is reloadable at runtime.
//   After a reload the line refills: outputs stay gated until D samples of
//   the new fill have been written.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   delay_in  - requested delay in samples (clamped to 1..DMAX)
//   delay_ld  - one-cycle strobe loading delay_in, restarts the fill
//   in_valid  - data_in carries a sample
//   data_in   - CH samples of W bits, channel c at [c*W +: W]
//   out_valid - data_out carries a delayed sample (one clk after in_valid)
//   data_out  - delayed samples, same packing; holds while out_valid is low
//   busy      - high while the line refills
module dpd_align_delay
  import dpd_pkg::*;
#(
  parameter int W    = 16,
  parameter int CH   = 2,
  parameter int DMAX = 64,
  parameter int DDEF = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(DMAX):0]   delay_in,
  input  logic                    delay_ld,
  input  logic                    in_valid,
  input  logic [CH*W-1:0]         data_in,
  output logic                    out_valid,
  output logic [CH*W-1:0]         data_out,
  output logic                    busy
);

  localparam int AW = $clog2(DMAX);
  localparam int DW = AW + 1;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wp_reg;
  logic [DW-1:0]   fill_cnt_reg, fill_cnt_next;
  logic [DW-1:0]   d_reg, d_next;
  logic [DW-1:0]   d_clamped;
  logic            out_valid_reg;
  logic            busy_reg;
  logic            out_fire;
  logic [AW-1:0]   rd_addr;

  assign d_clamped = DW'(clamp_delay(int'({{(32-DW){1'b0}}, delay_in}), DMAX));

  // D = DMAX truncates to 0 here, so the read hits the word being
  // overwritten, which the RAM returns with its old contents.
  assign rd_addr = wp_reg - d_reg[AW-1:0];

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    d_next        = d_reg;
    out_fire      = 1'b0;
    if (delay_ld) begin
      // A coincident sample is sample 0 of the new fill; D >= 1 so it
      // never produces an output.
      d_next        = d_clamped;
      state_next    = ST_FILL;
      fill_cnt_next = in_valid ? DW'(1) : '0;
    end else if (in_valid) begin
      case (state_reg)
        ST_FILL: begin
          if (fill_cnt_reg == d_reg) begin
            out_fire   = 1'b1;
            state_next = ST_RUN;
          end else begin
            fill_cnt_next = fill_cnt_reg + DW'(1);
          end
        end
        ST_RUN: begin
          out_fire = 1'b1;
        end
        default: begin
          state_next = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      wp_reg        <= '0;
      fill_cnt_reg  <= '0;
      d_reg         <= DW'(DDEF);
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      d_reg         <= d_next;
      out_valid_reg <= out_fire;
      busy_reg      <= (state_next == ST_FILL);
      if (in_valid) begin
        wp_reg <= wp_reg + AW'(1);
      end
    end
  end

  // The read register only loads on an emitted sample, so data_out holds
  // between outputs and reads 0 after reset.
  delay_ram #(
    .DEPTH (DMAX),
    .WIDTH (CH*W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (in_valid && !rst),
    .waddr (wp_reg),
    .wdata (data_in),
    .re    (out_fire),
    .raddr (rd_addr),
    .rdata (data_out)
  );

  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule
